// File: rtl/mmio_port_unit.sv
// CPU data-port splitter: data RAM vs. I/O window holding a TX byte FIFO, a compare timer and a sticky irq.
// Timer/compare/irq logic is built only when MMIO_TIMER_EN is defined; otherwise those registers read 0.
module mmio_port_unit #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_memwrite,
  input  logic [31:0] cpu_memaddr,
  input  logic [31:0] cpu_memwritedata,
  output logic [31:0] cpu_memreaddata,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int         AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  localparam logic [5:0] OFF_TXDATA = 6'h00;
  localparam logic [5:0] OFF_STATUS = 6'h01;
  localparam logic [5:0] OFF_TIMER  = 6'h02;
  localparam logic [5:0] OFF_TCMP   = 6'h03;
  localparam logic [5:0] OFF_CTRL   = 6'h04;
  localparam logic [5:0] OFF_ISTAT  = 6'h05;

  logic        io_sel;
  logic [5:0]  word_off;
  logic        io_we;
  logic [31:0] io_rdata;

  // Address bits [1:0] never take part in decode; word offset is addr[7:2].
  assign io_sel   = (cpu_memaddr[31:8] == IO_BASE[31:8]);
  assign word_off = cpu_memaddr[7:2];
  assign io_we    = cpu_memwrite & io_sel;

  assign ram_we          = cpu_memwrite & ~io_sel;
  assign ram_addr        = cpu_memaddr;
  assign ram_wdata       = cpu_memwritedata;
  assign cpu_memreaddata = io_sel ? io_rdata : ram_rdata;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          ovf;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_req;
  logic          push_ok;
  logic          ovf_set;
  logic          ovf_clr;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign pop      = tx_valid & tx_ready;
  assign push_req = io_we & (word_off == OFF_TXDATA);
  // A pop in the same cycle frees the slot the push needs, so a full FIFO still accepts it.
  assign push_ok  = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;
  assign ovf_clr  = io_we & (word_off == OFF_STATUS) & cpu_memwritedata[2];

  assign tx_valid = ~empty;
  assign tx_data  = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= cpu_memwritedata[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  logic [31:0] status_rd;
  logic [31:0] timer_rd;
  logic [31:0] tcmp_rd;
  logic [31:0] ctrl_rd;
  logic [31:0] istat_rd;

  assign status_rd = {16'b0, 8'(count), 5'b0, ovf, full, empty};

`ifdef MMIO_TIMER_EN
  logic [31:0] timer;
  logic [31:0] tcmp;
  logic        tmr_en;
  logic        irq_en;
  logic        tmr_hit;
  logic        irq_q;
  logic        hit;
  logic        tmr_hit_next;
  logic [31:0] timer_next;

  // A CPU store to TIMER beats both the increment and the match reload;
  // a hit on the pre-edge value still sets tmr_hit, and a set beats a same-cycle W1C.
  always_comb begin
    hit        = tmr_en & (timer == tcmp);
    timer_next = timer;
    if (io_we && (word_off == OFF_TIMER)) begin
      timer_next = cpu_memwritedata;
    end else if (tmr_en) begin
      timer_next = hit ? 32'd0 : timer + 32'd1;
    end
    tmr_hit_next = tmr_hit;
    if (io_we && (word_off == OFF_ISTAT) && cpu_memwritedata[0]) begin
      tmr_hit_next = 1'b0;
    end
    if (hit) begin
      tmr_hit_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer   <= '0;
      tcmp    <= '0;
      tmr_en  <= 1'b0;
      irq_en  <= 1'b0;
      tmr_hit <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      timer   <= timer_next;
      tmr_hit <= tmr_hit_next;
      irq_q   <= irq_en & tmr_hit_next;
      if (io_we && (word_off == OFF_TCMP)) begin
        tcmp <= cpu_memwritedata;
      end
      if (io_we && (word_off == OFF_CTRL)) begin
        tmr_en <= cpu_memwritedata[0];
        irq_en <= cpu_memwritedata[1];
      end
    end
  end

  assign timer_rd = timer;
  assign tcmp_rd  = tcmp;
  assign ctrl_rd  = {30'b0, irq_en, tmr_en};
  assign istat_rd = {31'b0, tmr_hit};
  assign irq      = irq_q;
`else
  assign timer_rd = '0;
  assign tcmp_rd  = '0;
  assign ctrl_rd  = '0;
  assign istat_rd = '0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    io_rdata = '0;
    case (word_off)
      OFF_STATUS: io_rdata = status_rd;
      OFF_TIMER:  io_rdata = timer_rd;
      OFF_TCMP:   io_rdata = tcmp_rd;
      OFF_CTRL:   io_rdata = ctrl_rd;
      OFF_ISTAT:  io_rdata = istat_rd;
      default:    io_rdata = '0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{cpu_memaddr[1:0], cpu_memwritedata};

endmodule

// File: tb/tb_mmio_port_unit.sv
// Bench for mmio_port_unit: directed FIFO/timer scenarios plus a randomized FIFO run against a queue model.
module tb_mmio_port_unit;

  localparam int          DEPTH = 8;
  localparam logic [31:0] IOB   = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_memwrite;
  logic [31:0] cpu_memaddr;
  logic [31:0] cpu_memwritedata;
  logic [31:0] cpu_memreaddata;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        irq;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [31:0] ram_mem [64];
  logic [7:0]  q [$];
  bit          m_ovf;

  always #5 clk = ~clk;

  assign ram_rdata = ram_mem[ram_addr[7:2]];
  always @(posedge clk) if (ram_we) ram_mem[ram_addr[7:2]] <= ram_wdata;

  mmio_port_unit #(.FIFO_DEPTH(DEPTH), .IO_BASE(IOB)) dut (
    .clk(clk), .reset(reset),
    .cpu_memwrite(cpu_memwrite), .cpu_memaddr(cpu_memaddr),
    .cpu_memwritedata(cpu_memwritedata), .cpu_memreaddata(cpu_memreaddata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .irq(irq)
  );

  // Bus helpers: entered and left at a falling edge.
  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    cpu_memwrite = 1'b1; cpu_memaddr = a; cpu_memwritedata = d;
    @(posedge clk); @(negedge clk);
    cpu_memwrite = 1'b0;
  endtask

  task automatic lw(input logic [31:0] a, output logic [31:0] d);
    cpu_memwrite = 1'b0; cpu_memaddr = a;
    #1 d = cpu_memreaddata;
  endtask

  task automatic step();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    lw(IOB + 4, d);
    chk_cnt++; if (d !== 32'h1) $display("FAIL rst_status: got %h want 00000001", d); else pass_cnt++;
    chk_cnt++; if (tx_valid !== 1'b0) $display("FAIL rst_tx_valid: got %b want 0", tx_valid); else pass_cnt++;
    chk_cnt++; if (irq !== 1'b0) $display("FAIL rst_irq: got %b want 0", irq); else pass_cnt++;
    lw(32'h0000_0040, d);
    chk_cnt++; if (d !== 32'hCAFE_0040) $display("FAIL rst_ram_read: got %h want cafe0040", d); else pass_cnt++;
  endtask

  task automatic test_fifo_fill();
    logic [31:0] d;
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cpu_memwrite = 1'b1; cpu_memaddr = IOB; cpu_memwritedata = 32'h41 + i;
      #1;
      chk_cnt++; if (ram_we !== 1'b0) $display("FAIL t2_ram_we[%0d]: got %b want 0", i, ram_we); else pass_cnt++;
      step();
    end
    cpu_memwrite = 1'b0;
    lw(IOB + 4, d);
    chk_cnt++; if (d !== 32'h0000_0806) $display("FAIL t2_status: got %h want 00000806", d); else pass_cnt++;
    chk_cnt++; if (tx_data !== 8'h41) $display("FAIL t2_tx_data: got %h want 41", tx_data); else pass_cnt++;
  endtask

  task automatic test_drain();
    logic [31:0] d;
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk_cnt++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i))
        $display("FAIL t3_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, 8'(8'h41 + i));
      else pass_cnt++;
      step();
    end
    #1;
    chk_cnt++; if (tx_valid !== 1'b0) $display("FAIL t3_valid_drop: got %b want 0", tx_valid); else pass_cnt++;
    lw(IOB + 4, d);
    chk_cnt++; if (d !== 32'h5) $display("FAIL t3_status: got %h want 00000005", d); else pass_cnt++;
    tx_ready = 1'b0;
    sw(IOB + 4, 32'h4);
    lw(IOB + 4, d);
    chk_cnt++; if (d !== 32'h1) $display("FAIL t3_ovf_clear: got %h want 00000001", d); else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d;
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) sw(IOB, 32'h10 + i);
    tx_ready = 1'b1;
    sw(IOB, 32'h5A);
    tx_ready = 1'b0;
    lw(IOB + 4, d);
    chk_cnt++; if (d !== 32'h0000_0802) $display("FAIL t4_status: got %h want 00000802", d); else pass_cnt++;
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk_cnt++;
      if (tx_valid !== 1'b1 || tx_data !== ((i == 7) ? 8'h5A : 8'(8'h11 + i)))
        $display("FAIL t4_order[%0d]: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data,
                 (i == 7) ? 8'h5A : 8'(8'h11 + i));
      else pass_cnt++;
      step();
    end
    #1;
    chk_cnt++; if (tx_valid !== 1'b0) $display("FAIL t4_empty: got %b want 0", tx_valid); else pass_cnt++;
    tx_ready = 1'b0;
  endtask

  task automatic test_random_fifo();
    logic [31:0] d;
    logic [31:0] exp_st;
    int act;
    bit push, clr, rdy, pop, was_full;
    logic [7:0] b;
    q.delete();
    m_ovf = 0;
    for (int c = 0; c < 400; c++) begin
      act  = $urandom_range(0, 9);
      rdy  = ($urandom_range(0, 99) < 45);
      push = 0; clr = 0;
      b    = 8'($urandom);
      tx_ready = rdy;
      if (act < 5) begin
        push = 1;
        cpu_memwrite = 1'b1; cpu_memaddr = IOB | 32'($urandom_range(0, 3));
        cpu_memwritedata = {24'($urandom), b};
      end else if (act == 5) begin
        clr = 1;
        cpu_memwrite = 1'b1; cpu_memaddr = IOB + 4; cpu_memwritedata = 32'h4;
      end else begin
        cpu_memwrite = 1'b0; cpu_memaddr = IOB + 4;
      end
      #1;
      chk_cnt++;
      if (tx_valid !== (q.size() != 0))
        $display("FAIL rnd_valid[%0d]: got %b want %b", c, tx_valid, q.size() != 0);
      else pass_cnt++;
      if (q.size() != 0) begin
        chk_cnt++;
        if (tx_data !== q[0]) $display("FAIL rnd_data[%0d]: got %h want %h", c, tx_data, q[0]);
        else pass_cnt++;
      end
      if (act > 5) begin
        d = cpu_memreaddata;
        exp_st = {16'b0, 8'(q.size()), 5'b0, m_ovf, q.size() == DEPTH, q.size() == 0};
        chk_cnt++;
        if (d !== exp_st) $display("FAIL rnd_status[%0d]: got %h want %h", c, d, exp_st);
        else pass_cnt++;
      end
      @(posedge clk);
      pop      = rdy && (q.size() != 0);
      was_full = (q.size() == DEPTH);
      if (pop) void'(q.pop_front());
      if (push) begin
        if (!was_full || pop) q.push_back(b);
        else m_ovf = 1;
      end
      if (clr) m_ovf = 0;
      @(negedge clk);
    end
    cpu_memwrite = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) step();
    tx_ready = 1'b0;
  endtask

  task automatic test_ram_and_unmapped();
    logic [31:0] d;
    cpu_memwrite = 1'b1; cpu_memaddr = 32'h0000_0080; cpu_memwritedata = 32'h1234_5678;
    #1;
    chk_cnt++; if (ram_we !== 1'b1 || ram_addr !== 32'h80 || ram_wdata !== 32'h1234_5678)
      $display("FAIL ram_pass: got we=%b a=%h d=%h want we=1 a=00000080 d=12345678", ram_we, ram_addr, ram_wdata);
    else pass_cnt++;
    step();
    cpu_memwrite = 1'b0;
    lw(32'h0000_0080, d);
    chk_cnt++; if (d !== 32'h1234_5678) $display("FAIL ram_readback: got %h want 12345678", d); else pass_cnt++;
    sw(IOB + 32'h20, 32'hFFFF_FFFF);
    lw(IOB + 32'h20, d);
    chk_cnt++; if (d !== 32'h0) $display("FAIL unmapped_read: got %h want 0", d); else pass_cnt++;
    lw(IOB, d);
    chk_cnt++; if (d !== 32'h0) $display("FAIL txdata_read: got %h want 0", d); else pass_cnt++;
  endtask

`ifdef MMIO_TIMER_EN
  task automatic test_timer();
    logic [31:0] d;
    logic [31:0] e;
    sw(IOB + 32'h0C, 32'd3);
    sw(IOB + 32'h10, 32'd3);
    for (int k = 0; k < 4; k++) begin
      lw(IOB + 8, d);
      lw(IOB + 32'h14, e);
      chk_cnt++;
      if (d !== 32'(k) || e !== 32'h0 || irq !== 1'b0)
        $display("FAIL tmr_count[%0d]: got t=%0d h=%0d irq=%b want t=%0d h=0 irq=0", k, d, e, irq, k);
      else pass_cnt++;
      step();
    end
    lw(IOB + 8, d);
    lw(IOB + 32'h14, e);
    chk_cnt++;
    if (d !== 32'h0 || e !== 32'h1 || irq !== 1'b1)
      $display("FAIL tmr_hit: got t=%0d h=%0d irq=%b want t=0 h=1 irq=1", d, e, irq);
    else pass_cnt++;
    sw(IOB + 32'h14, 32'h1);
    lw(IOB + 32'h14, e);
    chk_cnt++;
    if (e !== 32'h0 || irq !== 1'b0) $display("FAIL tmr_w1c: got h=%0d irq=%b want h=0 irq=0", e, irq);
    else pass_cnt++;
    step(); step();
    lw(IOB + 8, d);
    chk_cnt++; if (d !== 32'd3) $display("FAIL tmr_pre_hit: got %0d want 3", d); else pass_cnt++;
    sw(IOB + 32'h14, 32'h1);
    lw(IOB + 32'h14, e);
    lw(IOB + 8, d);
    chk_cnt++;
    if (e !== 32'h1 || irq !== 1'b1 || d !== 32'h0)
      $display("FAIL tmr_set_wins: got h=%0d irq=%b t=%0d want h=1 irq=1 t=0", e, irq, d);
    else pass_cnt++;
    sw(IOB + 32'h10, 32'h0);
    step();
    lw(IOB + 8, d);
    chk_cnt++;
    if (d !== 32'd1 || irq !== 1'b0) $display("FAIL tmr_disable: got t=%0d irq=%b want t=1 irq=0", d, irq);
    else pass_cnt++;
    sw(IOB + 8, 32'd100);
    step();
    lw(IOB + 8, d);
    chk_cnt++; if (d !== 32'd100) $display("FAIL tmr_write_hold: got %0d want 100", d); else pass_cnt++;
    lw(IOB + 32'h10, d);
    chk_cnt++; if (d !== 32'h0) $display("FAIL ctrl_read: got %h want 0", d); else pass_cnt++;
  endtask
`else
  task automatic test_no_timer();
    logic [31:0] d;
    logic [31:0] offs [4];
    offs[0] = 32'h08; offs[1] = 32'h0C; offs[2] = 32'h10; offs[3] = 32'h14;
    for (int k = 0; k < 4; k++) sw(IOB + offs[k], 32'hFFFF_FFFF);
    for (int k = 0; k < 4; k++) begin
      lw(IOB + offs[k], d);
      chk_cnt++; if (d !== 32'h0) $display("FAIL notmr_read[%h]: got %h want 0", offs[k], d); else pass_cnt++;
    end
    for (int k = 0; k < 20; k++) begin
      #1;
      chk_cnt++; if (irq !== 1'b0) $display("FAIL notmr_irq[%0d]: got %b want 0", k, irq); else pass_cnt++;
      step();
    end
  endtask
`endif

  task automatic test_reset_mid_drain();
    logic [31:0] d;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) sw(IOB, 32'h70 + i);
    tx_ready = 1'b1;
    step();
    #2 reset = 1'b0;
    #1;
    chk_cnt++; if (tx_valid !== 1'b0 || irq !== 1'b0)
      $display("FAIL t1_outputs: got v=%b irq=%b want v=0 irq=0", tx_valid, irq);
    else pass_cnt++;
    lw(IOB + 4, d);
    chk_cnt++; if (d !== 32'h1) $display("FAIL t1_status: got %h want 00000001", d); else pass_cnt++;
    lw(32'h0000_0040, d);
    chk_cnt++; if (d !== 32'hCAFE_0040) $display("FAIL t1_ram_read: got %h want cafe0040", d); else pass_cnt++;
    cpu_memwrite = 1'b1; cpu_memaddr = 32'h0000_0040; cpu_memwritedata = 32'h0;
    #1;
    chk_cnt++; if (ram_we !== 1'b1) $display("FAIL t1_ram_we: got %b want 1", ram_we); else pass_cnt++;
    cpu_memwrite = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();
    #1;
    chk_cnt++; if (tx_valid !== 1'b0) $display("FAIL t1_after_release: got %b want 0", tx_valid); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram_mem[i] = 32'h0;
    ram_mem[16] = 32'hCAFE_0040;
    reset = 1'b0; cpu_memwrite = 1'b0; cpu_memaddr = 32'h0; cpu_memwritedata = 32'h0; tx_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    test_reset();
    reset = 1'b1;
    step();
    test_fifo_fill();
    test_drain();
    test_full_push_pop();
    test_random_fifo();
    test_ram_and_unmapped();
`ifdef MMIO_TIMER_EN
    test_timer();
`else
    test_no_timer();
`endif
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
